// File: rtl/retire_trace_ctrl_if.sv
// Retire/trace bus bundle: the retire-event offer from the CPU and the
// show-ahead trace head handed to the consumer.
//   master : environment side (CPU drives retire fields, consumer drives ready)
//   slave  : trace controller side
interface retire_trace_ctrl_if;
    logic        retired;
    logic [1:0]  kind;
    logic [15:0] pc;
    logic [15:0] addr;
    logic [15:0] data;
    logic        trace_ready;
    logic        trace_valid;
    logic [1:0]  trace_kind;
    logic [15:0] trace_pc;
    logic [15:0] trace_addr;
    logic [15:0] trace_data;
    logic [15:0] trace_seq;

    modport master (
        output retired, kind, pc, addr, data, trace_ready,
        input  trace_valid, trace_kind, trace_pc, trace_addr, trace_data, trace_seq
    );

    modport slave (
        input  retired, kind, pc, addr, data, trace_ready,
        output trace_valid, trace_kind, trace_pc, trace_addr, trace_data, trace_seq
    );
endinterface

// File: rtl/retire_trace_ctrl.sv
// Retire trace controller: stamps retire events with a sequence number and
// buffers them in a show-ahead FIFO for a trace consumer. Events that find
// the FIFO full are dropped and counted. After halt, new events are ignored
// and the FIFO drains; done rises once everything accepted is delivered.
module retire_trace_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    retire_trace_ctrl_if.slave       bus,
    input  logic                     halt,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 2 + 16 + 16 + 16 + 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [15:0]     seq_q, seq_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    // Entry layout: {kind, pc, addr, data, seq}
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   wr_entry;
    logic [EW-1:0]   head;

    logic            pop;
    logic            offer;
    logic            push;
    logic            drop;
    logic            head_valid;

    // Push/pop decisions and the resulting pointer, level and counter updates
    always_comb begin
        head_valid = (level_q != '0);
        pop        = head_valid && bus.trace_ready;
        offer      = bus.retired && (bus.kind != 2'd3) && (state_q == ST_RUN);
        // A full FIFO still takes the offer when the head leaves this cycle
        push       = offer && ((level_q != LW'(DEPTH)) || pop);
        drop       = offer && !push;

        wr_entry   = {bus.kind, bus.pc, bus.addr, bus.data, seq_q};

        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        level_d    = level_q + LW'(push) - LW'(pop);
        seq_d      = push ? seq_q + 16'd1 : seq_q;
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Run/drain/done sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // No pushes happen in drain, so this is "empty after this edge"
                if ((level_q == '0) || ((level_q == LW'(1)) && pop)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Control state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Show-ahead head, forced to zero whenever nothing is buffered
    always_comb begin
        head            = head_valid ? mem_q[rd_ptr_q] : '0;
        bus.trace_valid = head_valid;
        bus.trace_kind  = head[65:64];
        bus.trace_pc    = head[63:48];
        bus.trace_addr  = head[47:32];
        bus.trace_data  = head[31:16];
        bus.trace_seq   = head[15:0];
        level           = level_q;
        overflow        = overflow_q;
        drop_cnt        = drop_cnt_q;
        done            = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_retire_trace_ctrl.sv
// Bench for retire_trace_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_retire_trace_ctrl;
    localparam int DEPTH = 8;

    logic       clk;
    logic       rst_n;
    logic       halt;
    logic [3:0] level;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       done;

    retire_trace_ctrl_if bus();

    retire_trace_ctrl #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .halt     (halt),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]  kind;
        logic [15:0] pc;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] seq;
    } entry_t;

    entry_t      m_q[$];
    logic [15:0] m_seq;
    int          m_drop;
    bit          m_ovf;
    bit          m_halted;
    bit          m_done;

    task automatic model_reset();
        m_q.delete();
        m_seq    = 16'h0000;
        m_drop   = 0;
        m_ovf    = 0;
        m_halted = 0;
        m_done   = 0;
    endtask

    // Applies one clock edge's worth of behaviour using the inputs at that edge
    task automatic model_edge();
        bit     taken;
        entry_t e;
        taken = bus.retired && (bus.kind != 2'd3) && !m_halted;
        if ((m_q.size() != 0) && bus.trace_ready) begin
            void'(m_q.pop_front());
        end
        if (taken) begin
            if (m_q.size() < DEPTH) begin
                e.kind = bus.kind;
                e.pc   = bus.pc;
                e.addr = bus.addr;
                e.data = bus.data;
                e.seq  = m_seq;
                m_q.push_back(e);
                m_seq  = m_seq + 16'd1;
            end else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
        if (m_halted && (m_q.size() == 0)) m_done = 1;
        if (halt) m_halted = 1;
    endtask

    task automatic model_compare(input string tag);
        logic [79:0] exp_head;
        exp_head = '0;
        if (m_q.size() != 0) begin
            exp_head = {14'd0, m_q[0].kind, m_q[0].pc, m_q[0].addr, m_q[0].data, m_q[0].seq};
        end
        check({tag, "_valid"}, 80'(bus.trace_valid), 80'(m_q.size() != 0));
        check({tag, "_level"}, 80'(level), 80'(m_q.size()));
        check({tag, "_head"},
              {14'd0, bus.trace_kind, bus.trace_pc, bus.trace_addr, bus.trace_data, bus.trace_seq},
              exp_head);
        check({tag, "_ovf"}, 80'(overflow), 80'(m_ovf));
        check({tag, "_drop"}, 80'(drop_cnt), 80'(m_drop));
        check({tag, "_done"}, 80'(done), 80'(m_done));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic r, input logic [1:0] k, input logic [15:0] p,
                          input logic [15:0] a, input logic [15:0] d,
                          input logic h, input logic rdy);
        bus.retired     = r;
        bus.kind        = k;
        bus.pc          = p;
        bus.addr        = a;
        bus.data        = d;
        halt            = h;
        bus.trace_ready = rdy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 2'd0, 16'h0, 16'h0, 16'h0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        retired;
        logic [1:0]  kind;
        logic [15:0] pc;
        logic [15:0] addr;
        logic [15:0] data;
        logic        halt;
        logic        ready;
        logic        exp_valid;
        logic [3:0]  exp_level;
        logic [15:0] exp_seq;
        logic [15:0] exp_pc;
        logic        exp_ovf;
        logic [7:0]  exp_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [1:0] k, logic [15:0] p, logic [15:0] a,
                                logic [15:0] d, logic h, logic rdy, logic ev,
                                logic [3:0] el, logic [15:0] es, logic [15:0] ep,
                                logic eo, logic [7:0] ed);
        vec_t v;
        v.retired = r;  v.kind = k;  v.pc = p;  v.addr = a;  v.data = d;
        v.halt = h;  v.ready = rdy;  v.exp_valid = ev;  v.exp_level = el;
        v.exp_seq = es;  v.exp_pc = ep;  v.exp_ovf = eo;  v.exp_drop = ed;
        return v;
    endfunction

    initial begin
        // Single event, then gone the following cycle
        vecs.push_back(mk(1, 2'd0, 16'h0010, 16'h0003, 16'hBEEF, 0, 1,
                          1, 4'd1, 16'h0000, 16'h0010, 0, 8'd0));
        vecs.push_back(mk(0, 2'd0, 16'h0, 16'h0, 16'h0, 0, 1,
                          0, 4'd0, 16'h0, 16'h0, 0, 8'd0));
        // Reserved kind is ignored entirely
        vecs.push_back(mk(1, 2'd3, 16'h0777, 16'h0, 16'h0, 0, 0,
                          0, 4'd0, 16'h0, 16'h0, 0, 8'd0));
        // Ten offers into a stalled consumer: eight stored, two dropped
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(1, 2'd1, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 16'h0300 + 16'(i), 0, 0,
                              1, (i < 8) ? 4'(i + 1) : 4'd8, 16'h0001, 16'h0100,
                              (i >= 8), (i >= 8) ? 8'(i - 7) : 8'd0));
        end
        // Full with concurrent pop: offer accepted, level holds
        vecs.push_back(mk(1, 2'd1, 16'h01AA, 16'h02AA, 16'h03AA, 0, 1,
                          1, 4'd8, 16'h0002, 16'h0101, 1, 8'd2));
        // Drain in order
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mk(0, 2'd0, 16'h0, 16'h0, 16'h0, 0, 1,
                              (k < 8), 4'(8 - k), 16'(2 + k),
                              (k < 7) ? 16'h0101 + 16'(k) : 16'h01AA, 1, 8'd2));
        end

        rst_n = 1'b0;
        set_in(0, 2'd0, 16'h0, 16'h0, 16'h0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 80'(bus.trace_valid), 80'(0));
        check("rst_level", 80'(level), 80'(0));
        check("rst_ovf", 80'(overflow), 80'(0));
        check("rst_drop", 80'(drop_cnt), 80'(0));
        check("rst_done", 80'(done), 80'(0));
        check("rst_head", {bus.trace_kind, bus.trace_pc, bus.trace_addr, bus.trace_data, bus.trace_seq},
              80'(0));
        rst_n = 1'b1;

        // ---- table ----
        foreach (vecs[i]) begin
            set_in(vecs[i].retired, vecs[i].kind, vecs[i].pc, vecs[i].addr, vecs[i].data,
                   vecs[i].halt, vecs[i].ready);
            step();
            $display("vec %0d: ret=%0b kind=%0d pc=%h rdy=%0b -> valid=%0b level=%0d seq=%h drop=%0d",
                     i, vecs[i].retired, vecs[i].kind, vecs[i].pc, vecs[i].ready,
                     bus.trace_valid, level, bus.trace_seq, drop_cnt);
            check($sformatf("vec%0d_valid", i), 80'(bus.trace_valid), 80'(vecs[i].exp_valid));
            check($sformatf("vec%0d_level", i), 80'(level), 80'(vecs[i].exp_level));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_seq", i), 80'(bus.trace_seq), 80'(vecs[i].exp_seq));
                check($sformatf("vec%0d_pc", i), 80'(bus.trace_pc), 80'(vecs[i].exp_pc));
            end
            check($sformatf("vec%0d_ovf", i), 80'(overflow), 80'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_drop", i), 80'(drop_cnt), 80'(vecs[i].exp_drop));
            check($sformatf("vec%0d_done", i), 80'(done), 80'(0));
        end
        // First entry's full field set
        do_reset();
        set_in(1, 2'd0, 16'h0010, 16'h0003, 16'hBEEF, 0, 1);
        step();
        check("single_fields", {bus.trace_kind, bus.trace_pc, bus.trace_addr, bus.trace_data, bus.trace_seq},
              {2'd0, 16'h0010, 16'h0003, 16'hBEEF, 16'h0000});

        // ---- halt and drain ----
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 2'd0, 16'h0040 + 16'(i), 16'(i), 16'h1000 + 16'(i), 0, 0);
            step();
        end
        set_in(1, 2'd2, 16'h0050, 16'h0060, 16'h0, 1, 0);
        step();
        $display("halt: level=%0d done=%0b", level, done);
        check("halt_level", 80'(level), 80'(4));
        check("halt_done0", 80'(done), 80'(0));
        set_in(1, 2'd0, 16'h0099, 16'h0, 16'h0, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain%0d_seq", k), 80'(bus.trace_seq), 80'(k - 1));
            if (k == 4) check("drain_jump_kind", 80'(bus.trace_kind), 80'(2));
            step();
            $display("drain pop %0d: level=%0d done=%0b", k, level, done);
            check($sformatf("drain%0d_level", k), 80'(level), 80'(4 - k));
            check($sformatf("drain%0d_done", k), 80'(done), 80'(k == 4));
        end
        set_in(1, 2'd1, 16'h0, 16'h0, 16'h0, 1, 1);
        step();
        set_in(0, 2'd0, 16'h0, 16'h0, 16'h0, 0, 1);
        step();
        check("done_hold", 80'(done), 80'(1));
        check("done_level", 80'(level), 80'(0));
        check("done_nodrop", 80'(drop_cnt), 80'(0));

        // ---- async reset mid-operation ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 2'd1, 16'h0A00 + 16'(i), 16'h0, 16'h0, 0, 0);
            step();
        end
        check("areset_pre_level", 80'(level), 80'(5));
        #3;
        rst_n = 1'b0;
        #1;
        $display("async reset: valid=%0b level=%0d", bus.trace_valid, level);
        check("areset_valid", 80'(bus.trace_valid), 80'(0));
        check("areset_level", 80'(level), 80'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        set_in(1, 2'd0, 16'h0B00, 16'h0, 16'h0, 0, 0);
        step();
        check("areset_seq0", 80'(bus.trace_seq), 80'(0));
        check("areset_valid1", 80'(bus.trace_valid), 80'(1));

        // ---- drop counter saturation ----
        do_reset();
        set_in(1, 2'd1, 16'h0C00, 16'h0, 16'h0, 0, 0);
        for (int i = 0; i < 308; i++) begin
            step();
            if (i == 8) check("drop_first", 80'(drop_cnt), 80'(1));
        end
        $display("saturation: drop_cnt=%0d overflow=%0b level=%0d", drop_cnt, overflow, level);
        check("drop_sat", 80'(drop_cnt), 80'(8'hFF));
        check("drop_ovf", 80'(overflow), 80'(1));
        check("drop_level", 80'(level), 80'(DEPTH));

        // ---- sequence wrap ----
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            set_in(1, 2'd0, 16'(i), 16'h0, 16'h0, 0, 1);
            step();
            if (i == 65535) check("wrap_ffff", 80'(bus.trace_seq), 80'(16'hFFFF));
        end
        $display("wrap: last seq=%h valid=%0b", bus.trace_seq, bus.trace_valid);
        check("wrap_seq0", 80'(bus.trace_seq), 80'(0));
        check("wrap_valid", 80'(bus.trace_valid), 80'(1));

        // ---- randomized traffic against the model ----
        for (int round = 0; round < 2; round++) begin
            do_reset();
            for (int c = 0; c < 1500; c++) begin
                set_in(($urandom % 4) != 0, 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                       (c > 900) && (($urandom % 150) == 0),
                       (round == 0) ? (($urandom % 3) != 0) : (($urandom % 4) == 0));
                step();
                model_compare($sformatf("rnd%0d_c%0d", round, c));
            end
            $display("random round %0d: level=%0d drop=%0d done=%0b", round, level, drop_cnt, done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/retire_trace_ctrl.md
RETIRE_TRACE_CTRL -- requirements
Module: retire_trace_ctrl

Interface
REQ-001 Parameter: DEPTH, default 8, number of trace-FIFO entries; power of two, >= 2.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 retired  input  1  one retire event offered this cycle.
REQ-005 kind  input  2  event class: 0 = register write, 1 = memory write, 2 = taken jump, 3 = reserved.
REQ-006 pc  input  16  PC of the retiring instruction.
REQ-007 addr  input  16  register index (kind 0), memory address (kind 1), jump target (kind 2).
REQ-008 data  input  16  written value (kinds 0/1); don't-care for kind 2.
REQ-009 halt  input  1  CPU halt indication; level, sampled each cycle.
REQ-010 trace_ready  input  1  trace consumer accepts the head entry.
REQ-011 trace_valid  output  1  head entry available.
REQ-012 trace_kind/trace_pc/trace_addr/trace_data  output  2/16/16/16  head entry fields.
REQ-013 trace_seq  output  16  sequence number of the head entry.
REQ-014 level  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-015 overflow  output  1  sticky: at least one event dropped.
REQ-016 drop_cnt  output  8  dropped-event count, saturating.
REQ-017 done  output  1  halt seen and all accepted events delivered.

Function
REQ-018 The block SHALL be a show-ahead FIFO: trace_valid = (level != 0); head fields SHALL be valid whenever trace_valid = 1, with zero added latency beyond the push cycle (entry visible the cycle after push).
REQ-019 Pop SHALL occur on a cycle with trace_valid && trace_ready; the head fields SHALL hold stable while trace_valid && !trace_ready.
REQ-020 An offer is retired = 1, kind != 3, and state = RUN; kind 3 offers SHALL be ignored entirely (no push, no seq, no drop count).
REQ-021 An offer SHALL be pushed if level < DEPTH, or if level = DEPTH and a pop occurs the same cycle; otherwise it SHALL be dropped.
REQ-022 Simultaneous push and pop SHALL leave level unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-023 A 16-bit sequence counter SHALL stamp each pushed entry with its current value then increment, wrapping 0xFFFF -> 0x0000; dropped offers SHALL NOT increment it.
REQ-024 A dropped offer SHALL set overflow (held until reset) and increment drop_cnt, which saturates at 0xFF.
REQ-025 State machine: RUN, DRAIN, DONE.
REQ-026 RUN -> DRAIN when halt = 1; an offer in that same cycle SHALL still be handled under RUN rules (halting instruction's event is kept).
REQ-027 In DRAIN/DONE, offers SHALL be ignored (not pushed, not counted as drops); pops continue.
REQ-028 DRAIN -> DONE when level = 0, or level = 1 with a pop that cycle.
REQ-029 done SHALL equal 1 exactly in DONE; DONE SHALL persist until reset regardless of halt.
REQ-030 Halt deassertion in DRAIN SHALL NOT return to RUN.

Reset
REQ-031 While rst_n = 0: state = RUN, pointers/level = 0, seq counter = 0, trace_valid = 0, overflow = 0, drop_cnt = 0, done = 0; head data outputs = 0.
REQ-032 Reset mid-operation SHALL discard all buffered entries; the first push after release carries seq 0x0000.
REQ-033 Storage array contents need not be reset; only visible outputs are defined.

Verification
REQ-034 Single event: reset, kind=0 pc=0x0010 addr=3 data=0xBEEF, ready=1 -> next cycle valid=1 with those fields, seq=0x0000; following cycle valid=0, level=0.
REQ-035 Fill/overflow (DEPTH=8): ready=0, 10 consecutive kind-1 offers -> level=8, overflow=1, drop_cnt=2; draining yields seq 0..7 in order.
REQ-036 Full with concurrent pop: level=8, ready=1, one offer -> pushed, level stays 8, drop_cnt unchanged.
REQ-037 Halt: 3 entries buffered, halt=1 with a kind-2 offer same cycle -> 4 entries delivered; offers after halt ignored; done=1 the cycle after last pop.
REQ-038 Wrap/saturation: 65537 pushes -> the last entry carries seq 0x0000; 300 drops -> drop_cnt=0xFF.
REQ-039 Async reset: assert rst_n=0 between edges with level=5 -> valid=0, level=0 immediately; next push seq=0x0000.
